// File: rtl/fp_pkg.sv
// Shared binary32 field layout, exponent landmarks and operand classification
// for the single-op FPU units.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    // Exponent landmarks as exponent-width values so compares stay 8-bit.
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_INT = EXP_W'(BIAS + MAN_W);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        CLS_NAN_INF,
        CLS_ZERO,
        CLS_FRAC,
        CLS_INT,
        CLS_MIXED
    } fp_cls_e;

    // How many of the mantissa bits sit below the binary point decides the path.
    function automatic fp_cls_e fp_classify(input logic [EXP_W-1:0] e);
        fp_cls_e cls;
        if (e == EXP_MAX)
            cls = CLS_NAN_INF;
        else if (e == '0)
            cls = CLS_ZERO;
        else if (e < EXP_ONE)
            cls = CLS_FRAC;
        else if (e >= EXP_INT)
            cls = CLS_INT;
        else
            cls = CLS_MIXED;
        return cls;
    endfunction

endpackage

// File: rtl/fp_floor_core.sv
// Combinational binary32 floor: clears the fraction bits and, for negative
// operands with a non-zero fraction, bumps the magnitude to the next integer.
module fp_floor_core
    import fp_pkg::*;
(
    input  logic [31:0] i_src,
    output logic [31:0] o_dest
);

    fp32_t            w_in;
    fp32_t            w_out;
    fp_cls_e          w_cls;
    logic [4:0]       w_sh;
    logic [MAN_W-1:0] w_mask;
    logic [MAN_W-1:0] w_frac;
    logic [MAN_W-1:0] w_trunc;
    logic [MAN_W:0]   w_ulp;
    logic [MAN_W:0]   w_sum;

    assign w_in  = fp32_t'(i_src);
    assign w_cls = fp_classify(w_in.exp);

    // Only meaningful for CLS_MIXED, where the count lies in 1..23.
    assign w_sh    = 5'(EXP_INT - w_in.exp);
    assign w_mask  = ~({MAN_W{1'b1}} << w_sh);
    assign w_frac  = w_in.man & w_mask;
    assign w_trunc = w_in.man & ~w_mask;
    assign w_ulp   = (MAN_W+1)'(1) << w_sh;
    assign w_sum   = {1'b0, w_trunc} + w_ulp;

    always_comb begin
        w_out = w_in;
        unique case (w_cls)
            CLS_NAN_INF: w_out = w_in;
            CLS_ZERO: begin
                w_out      = '0;
                w_out.sign = w_in.sign;
            end
            CLS_FRAC: begin
                w_out = '0;
                if (w_in.sign) begin
                    w_out.sign = 1'b1;
                    w_out.exp  = EXP_ONE;
                end
            end
            CLS_INT: w_out = w_in;
            CLS_MIXED: begin
                w_out.man = w_trunc;
                if (w_in.sign && (w_frac != '0)) begin
                    // Carry past the hidden bit means the significand became 2.0.
                    if (w_sum[MAN_W]) begin
                        w_out.exp = w_in.exp + 1'b1;
                        w_out.man = '0;
                    end else begin
                        w_out.man = w_sum[MAN_W-1:0];
                    end
                end
            end
            default: w_out = w_in;
        endcase
    end

    assign o_dest = w_out;

endmodule

// File: rtl/fp_floor.sv
// Binary32 floor unit: combinational core followed by one result register
// with a valid tag; one operand per cycle, no backpressure.
module fp_floor
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] src,
    output logic        out_valid,
    output logic [31:0] dest
);

    logic [31:0] w_floor;
    logic        r_valid;
    logic [31:0] r_dest;

    fp_floor_core u_core (
        .i_src  (src),
        .o_dest (w_floor)
    );

    // dest holds the last result across idle cycles; only the tag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid)
                r_dest <= w_floor;
        end
    end

    assign out_valid = r_valid;
    assign dest      = r_dest;

endmodule

// File: tb/tb_fp_floor.sv
// Scoreboard bench for fp_floor: directed vectors, a per-exponent sweep
// against a real-arithmetic floor, hold behaviour and asynchronous reset.
module tb_fp_floor;

    typedef struct {
        logic [31:0] src;
        logic [31:0] exp;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] src;
    logic        out_valid;
    logic [31:0] dest;

    sb_t q[$];
    int  checks;
    int  errors;

    fp_floor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .src       (src),
        .out_valid (out_valid),
        .dest      (dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] s);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s src=%08h got=%08h expected=%08h", name, s, act, exp);
        end
    endtask

    // Independent floor: real arithmetic, then re-encode the integral result.
    function automatic logic [31:0] ref_floor(input logic [31:0] x);
        real         v;
        real         mag;
        int          ex;
        logic [31:0] r;
        v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(int'(x[30:23]) - 127));
        if (x[31])
            v = -v;
        v = $floor(v);
        if (v == 0.0)
            return 32'h0;
        mag = (v < 0.0) ? -v : v;
        ex  = 0;
        while (mag >= 2.0) begin
            mag = mag / 2.0;
            ex++;
        end
        r = {x[31], 8'(ex + 127), 23'($rtoi((mag - 1.0) * 8388608.0))};
        return r;
    endfunction

    task automatic issue(input logic [31:0] s, input logic [31:0] e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        src      = s;
        q.push_back('{src: s, exp: e});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'd0, 32'h0);
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got dest=%08h expected no result", dest);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("dest", dest, e.exp, e.src);
            end
        end
    end

    logic [31:0] dir_src [21];
    logic [31:0] dir_exp [21];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        src      = 32'h0;

        dir_src[0]  = 32'h40200000; dir_exp[0]  = 32'h40000000;
        dir_src[1]  = 32'h3F333333; dir_exp[1]  = 32'h00000000;
        dir_src[2]  = 32'hC0200000; dir_exp[2]  = 32'hC0400000;
        dir_src[3]  = 32'hBE99999A; dir_exp[3]  = 32'hBF800000;
        dir_src[4]  = 32'hC0400000; dir_exp[4]  = 32'hC0400000;
        dir_src[5]  = 32'hBFC00000; dir_exp[5]  = 32'hC0000000;
        dir_src[6]  = 32'hBFFFFFFF; dir_exp[6]  = 32'hC0000000;
        dir_src[7]  = 32'h4B000001; dir_exp[7]  = 32'h4B000001;
        dir_src[8]  = 32'hFF800000; dir_exp[8]  = 32'hFF800000;
        dir_src[9]  = 32'h7FC00001; dir_exp[9]  = 32'h7FC00001;
        dir_src[10] = 32'h80000000; dir_exp[10] = 32'h80000000;
        dir_src[11] = 32'h80000001; dir_exp[11] = 32'h80000000;
        dir_src[12] = 32'h00400000; dir_exp[12] = 32'h00000000;
        dir_src[13] = 32'h3F800000; dir_exp[13] = 32'h3F800000;
        dir_src[14] = 32'hBF800000; dir_exp[14] = 32'hBF800000;
        dir_src[15] = 32'hBF000000; dir_exp[15] = 32'hBF800000;
        dir_src[16] = 32'hC1200001; dir_exp[16] = 32'hC1300000;
        dir_src[17] = 32'hCAFFFFFF; dir_exp[17] = 32'hCB000000;
        dir_src[18] = 32'h4AFFFFFF; dir_exp[18] = 32'h4AFFFFFE;
        dir_src[19] = 32'h4B7FFFFF; dir_exp[19] = 32'h4B7FFFFF;
        dir_src[20] = 32'h3F7FFFFF; dir_exp[20] = 32'h00000000;

        #2;
        chk("reset_valid", 32'(out_valid), 32'd0, 32'h0);
        chk("reset_dest", dest, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++)
            issue(dir_src[i], dir_exp[i]);
        idle();
        drain("drain_directed");

        // dest must hold while in_valid is low, and out_valid must drop.
        issue(32'h40200000, 32'h40000000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src      = 32'hC0200000;
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("hold_valid", 32'(out_valid), 32'd0, src);
            chk("hold_dest", dest, 32'h40000000, src);
        end

        for (int ee = 1; ee <= 254; ee++) begin
            for (int k = 0; k < 100; k++) begin
                logic [22:0] man;
                logic [31:0] x;
                man = ($urandom_range(9) == 0) ? 23'h0 : 23'($urandom);
                x   = {1'($urandom), 8'(ee), man};
                issue(x, ref_floor(x));
            end
        end
        idle();
        drain("drain_sweep");

        // Asynchronous reset between edges drops everything in flight.
        issue(32'hC0200000, 32'hC0400000);
        issue(32'h40200000, 32'h40000000);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0, 32'h0);
        chk("async_rst_dest", dest, 32'h0, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_held_valid", 32'(out_valid), 32'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        src = 32'hBFC00000;
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("post_rst_valid", 32'(out_valid), 32'd0, src);
            chk("post_rst_dest", dest, 32'h0, src);
        end
        issue(32'hBFC00000, 32'hC0000000);
        idle();
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
